// File: rtl/vector_lane_pkg.sv
// Shared types and helpers for the SIMD vector lane: opcode/SEW encodings,
// element counting, illegal-opcode decode. VECTOR_LANE_MUL_EN enables opcode 8.
package vector_lane_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_MIN    = 4'd5,
    OP_MAX    = 4'd6,
    OP_MUL    = 4'd8,
    OP_REDSUM = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  typedef enum logic {
    RED_IDLE = 1'b0,
    RED_OPEN = 1'b1
  } red_state_e;

  localparam int ACC_W = 64;

  function automatic int elem_count(input sew_e sew, input int data_w);
    return data_w >> (3 + int'(sew));
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    logic ill;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_MIN, OP_MAX, OP_REDSUM: ill = 1'b0;
`ifdef VECTOR_LANE_MUL_EN
      OP_MUL:                    ill = 1'b0;
`else
      OP_MUL:                    ill = 1'b1;
`endif
      default:                   ill = 1'b1;
    endcase
    return ill;
  endfunction

  // Keeps only the low SEW bits, i.e. reduces a value modulo 2^SEW.
  function automatic logic [ACC_W-1:0] sew_trunc(input logic [ACC_W-1:0] v, input sew_e s);
    logic [ACC_W-1:0] r;
    case (s)
      SEW_8:   r = {56'd0, v[7:0]};
      SEW_16:  r = {48'd0, v[15:0]};
      SEW_32:  r = {32'd0, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vector_lane_if.sv
// Issue/writeback bundle of the vector lane. master = issue+writeback side,
// slave = the lane itself.
interface vector_lane_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 6
);
  import vector_lane_pkg::*;

  // Handshake: a beat moves when in_valid && in_ready, a result moves when
  // out_valid && out_ready; the sender holds its payload stable until then.
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_op;
  logic [1:0]          in_sew;
  logic [DATA_W-1:0]   in_a;
  logic [DATA_W-1:0]   in_b;
  logic [DATA_W/8-1:0] in_mask;
  logic                in_last;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [TAG_W-1:0]    out_tag;
  logic                out_illegal;
  logic                busy;
  red_state_e          dbg_state;

  modport master (
    output in_valid, in_op, in_sew, in_a, in_b, in_mask, in_last, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_illegal, busy, dbg_state
  );

  modport slave (
    input  in_valid, in_op, in_sew, in_a, in_b, in_mask, in_last, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_illegal, busy, dbg_state
  );

endinterface

// File: rtl/vector_lane_alu.sv
// Combinational SIMD element ALU with per-element masking, plus the masked
// element sum of operand B used by reductions. MUL exists only with VECTOR_LANE_MUL_EN.
module vector_lane_alu
  import vector_lane_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [3:0]          op,
  input  sew_e                sew,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [DATA_W/8-1:0] mask,
  output logic [DATA_W-1:0]   result,
  output logic                illegal,
  output logic [ACC_W-1:0]    red_part
);

  logic [3:0][DATA_W-1:0] res_by_sew;
  logic [3:0][ACC_W-1:0]  sum_by_sew;

  for (genvar gw = 0; gw < 4; gw++) begin : g_sew
    localparam int EW = 8 << gw;
    localparam int NE = elem_count(sew_e'(gw), DATA_W);
    logic [EW-1:0] sum;

    for (genvar ge = 0; ge < NE; ge++) begin : g_el
      logic [EW-1:0] ea;
      logic [EW-1:0] eb;
      logic [EW-1:0] r;
      assign ea = a[ge*EW +: EW];
      assign eb = b[ge*EW +: EW];

      always_comb begin
        r = '0;
        case (op)
          OP_ADD: r = ea + eb;
          OP_SUB: r = ea - eb;
          OP_AND: r = ea & eb;
          OP_OR:  r = ea | eb;
          OP_XOR: r = ea ^ eb;
          OP_MIN: r = ($signed(ea) < $signed(eb)) ? ea : eb;
          OP_MAX: r = ($signed(ea) > $signed(eb)) ? ea : eb;
`ifdef VECTOR_LANE_MUL_EN
          // Low half of a two's-complement product is sign-agnostic.
          OP_MUL: r = ea * eb;
`endif
          default: r = '0;
        endcase
      end

      assign res_by_sew[gw][ge*EW +: EW] = mask[ge*(EW/8)] ? r : ea;
    end

    always_comb begin
      sum = '0;
      for (int i = 0; i < NE; i++) begin
        if (mask[i*(EW/8)]) sum = sum + b[i*EW +: EW];
      end
    end

    assign sum_by_sew[gw] = ACC_W'(sum);
  end

  assign illegal  = op_illegal(op);
  assign result   = illegal ? '0 : res_by_sew[sew];
  assign red_part = sum_by_sew[sew];

endmodule

// File: rtl/vector_lane.sv
// SIMD vector lane top: reduction accumulator/FSM, STAGES-deep result pipeline
// with global stall. MUL support follows VECTOR_LANE_MUL_EN (see the ALU).
module vector_lane
  import vector_lane_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int STAGES = 3,
  parameter int TAG_W  = 6
) (
  input logic          clk,
  input logic          reset,
  vector_lane_if.slave bus
);

  logic                advance;
  logic                accept;
  logic                is_red;
  sew_e                in_sew;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_illegal;
  logic [ACC_W-1:0]    red_part;

  red_state_e          state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  sew_e                red_sew_q, red_sew_d;
  logic                fault_q, fault_d;
  logic                red_mismatch;
  logic                red_illegal;
  logic [ACC_W-1:0]    red_sum;

  logic                s0_valid;
  logic [DATA_W-1:0]   s0_data;
  logic                s0_illegal;

  logic [STAGES-1:0]   valid_q;
  logic [STAGES-1:0]   ill_q;
  logic [DATA_W-1:0]   data_q [STAGES];
  logic [TAG_W-1:0]    tag_q  [STAGES];

  assign in_sew  = sew_e'(bus.in_sew);
  assign is_red  = (bus.in_op == OP_REDSUM);
  assign advance = bus.out_ready || !valid_q[STAGES-1];
  assign accept  = bus.in_valid && advance;
  assign bus.in_ready = advance;

  vector_lane_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (bus.in_op),
    .sew      (in_sew),
    .a        (bus.in_a),
    .b        (bus.in_b),
    .mask     (bus.in_mask),
    .result   (alu_result),
    .illegal  (alu_illegal),
    .red_part (red_part)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    red_sew_d    = red_sew_q;
    fault_d      = fault_q;
    red_mismatch = (state_q == RED_OPEN) && (in_sew != red_sew_q);
    red_illegal  = fault_q || red_mismatch;
    red_sum      = (state_q == RED_OPEN) ? sew_trunc(acc_q + red_part, red_sew_q)
                                         : sew_trunc(red_part, in_sew);
    if (accept && is_red) begin
      if (bus.in_last) begin
        state_d = RED_IDLE;
        acc_d   = '0;
        fault_d = 1'b0;
      end else begin
        state_d = RED_OPEN;
        acc_d   = red_sum;
        fault_d = red_illegal;
        if (state_q == RED_IDLE) red_sew_d = in_sew;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RED_IDLE;
      acc_q     <= '0;
      red_sew_q <= SEW_8;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      red_sew_q <= red_sew_d;
      fault_q   <= fault_d;
    end
  end

  // Non-last reduction beats enter the pipeline as bubbles.
  always_comb begin
    s0_valid   = accept && !(is_red && !bus.in_last);
    s0_illegal = is_red ? red_illegal : alu_illegal;
    s0_data    = alu_result;
    if (is_red) s0_data = red_illegal ? '0 : DATA_W'(red_sum);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      ill_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= s0_valid;
      ill_q[0]   <= s0_illegal;
      data_q[0]  <= s0_data;
      tag_q[0]   <= bus.in_tag;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        ill_q[i]   <= ill_q[i-1];
        data_q[i]  <= data_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign bus.out_valid   = valid_q[STAGES-1];
  assign bus.out_data    = data_q[STAGES-1];
  assign bus.out_tag     = tag_q[STAGES-1];
  assign bus.out_illegal = ill_q[STAGES-1];
  assign bus.busy        = (|valid_q) || (state_q == RED_OPEN);
  assign bus.dbg_state   = state_q;

endmodule
